// File: rtl/gen_st_multi.sv
// gen_st_multi: multi-channel, phase-staggered strobe generator.
// Emits NCH one-cycle enables per programmable period, evenly spread over
// the period, in continuous (level-gated), burst or single-shot mode.
module gen_st_multi #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int S   = $clog2(NCH),
  parameter int BW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   period,
  input  logic [BW-1:0]  burst_len,
  output logic [NCH-1:0] ce_st,
  output logic           busy,
  output logic           done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [1:0]    M_CONT   = 2'b00;
  localparam logic [1:0]    M_BURST  = 2'b01;
  localparam logic [1:0]    M_SINGLE = 2'b10;
  localparam logic [W-1:0]  NCH_W    = W'(NCH);
  localparam logic [BW-1:0] ONE_BW   = BW'(1);

  state_t        r_state;
  logic [W-1:0]  r_cb;
  logic [BW-1:0] r_rem;
  logic [W-1:0]  r_p_l;
  logic [1:0]    r_mode_l;
  logic          r_start_q;
  logic          r_done;

  state_t        w_state_nxt;
  logic [W-1:0]  w_cb_nxt;
  logic [BW-1:0] w_rem_nxt;
  logic          w_done_nxt;
  logic          w_load;
  logic          w_rise;
  logic          w_last;
  logic          w_gate;
  logic [W-1:0]  w_p_clamp;
  logic [W-1:0]  w_step;

  // Clamping the period to NCH keeps every channel offset distinct.
  assign w_p_clamp = (period < NCH_W) ? NCH_W : period;
  assign w_rise    = start & ~r_start_q;
  assign w_last    = (r_cb == (r_p_l - 1'b1));
  assign w_step    = r_p_l >> S;
  assign w_gate    = (r_mode_l != M_CONT) | en;
  assign done      = r_done;

  // State register plus counters, edge detector and done flag (async reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cb      <= '0;
      r_rem     <= '0;
      r_start_q <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cb      <= w_cb_nxt;
      r_rem     <= w_rem_nxt;
      r_start_q <= start;
      r_done    <= w_done_nxt;
    end
  end

  // Period and mode are captured only on entry to RUN and held until exit.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_p_l    <= w_p_clamp;
      r_mode_l <= mode;
    end
  end

  // Next-state logic: entry conditions, period counting and exit rules.
  always_comb begin
    w_state_nxt = r_state;
    w_cb_nxt    = r_cb;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cb_nxt = '0;
        if ((mode == M_CONT) && en) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else if ((mode == M_BURST) && w_rise && (burst_len != '0)) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
          w_rem_nxt   = burst_len;
        end else if ((mode == M_SINGLE) && w_rise) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
          w_rem_nxt   = ONE_BW;
        end
      end
      ST_RUN: begin
        w_cb_nxt = w_last ? '0 : (r_cb + 1'b1);
        if (r_mode_l == M_CONT) begin
          // Continuous mode drops out as soon as the gate or mode goes away.
          if (!en || (mode != M_CONT)) begin
            w_state_nxt = ST_IDLE;
            w_cb_nxt    = '0;
          end
        end else if (w_last) begin
          // Burst/single: count down whole periods, flag done on the last.
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == ONE_BW) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: busy in RUN, channel k strobes when the counter hits k*(P_l>>S).
  always_comb begin
    logic [W-1:0] off;
    off   = '0;
    ce_st = '0;
    busy  = (r_state == ST_RUN);
    for (int k = 0; k < NCH; k++) begin
      ce_st[k] = busy & w_gate & (r_cb == off);
      off      = off + w_step;
    end
  end

endmodule

// File: tb/tb_gen_st_multi.sv
// Testbench for gen_st_multi: cycle-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_gen_st_multi;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int BW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b11;
  logic [W-1:0]   period = 16'd8;
  logic [BW-1:0]  burst_len = 8'd0;
  logic [NCH-1:0] ce_st;
  logic           busy;
  logic           done;

  int n_chk = 0;
  int n_pass = 0;

  gen_st_multi #(.W(W), .NCH(NCH), .S(2), .BW(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .period(period), .burst_len(burst_len),
    .ce_st(ce_st), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: tracks elapsed RUN cycles since entry.
  int cyc = 0;
  bit m_run = 0, m_cont = 0, m_done = 0, m_sq = 0, m_rise = 0, m_done_n = 0;
  int m_el = 0, m_P = 4, m_L = 0, m_clamp = 4;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_done = 0; m_sq = 0; m_el = 0;
    end else begin
      m_rise   = start && !m_sq;
      m_sq     = start;
      m_done_n = 0;
      m_clamp  = (int'(period) < NCH) ? NCH : int'(period);
      if (!m_run) begin
        if (mode == 2'b00 && en) begin
          m_run = 1; m_cont = 1; m_el = 0; m_P = m_clamp;
        end else if (mode == 2'b01 && m_rise && burst_len != 0) begin
          m_run = 1; m_cont = 0; m_el = 0; m_P = m_clamp; m_L = int'(burst_len);
        end else if (mode == 2'b10 && m_rise) begin
          m_run = 1; m_cont = 0; m_el = 0; m_P = m_clamp; m_L = 1;
        end
      end else if (m_cont) begin
        if (!en || mode != 2'b00) m_run = 0;
        else m_el++;
      end else begin
        if (m_el == m_L * m_P - 1) begin
          m_run = 0; m_done_n = 1;
        end else m_el++;
      end
      m_done = m_done_n;
      cyc++;
    end
  end

  function automatic logic [NCH-1:0] exp_ce();
    logic [NCH-1:0] e;
    e = '0;
    for (int k = 0; k < NCH; k++)
      if (m_run && ((m_el % m_P) == k * (m_P / NCH)) && (!m_cont || en)) e[k] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    else n_pass++;
  endtask

  // Statistics over a window, gathered from DUT outputs.
  int cnt[NCH];
  int first[NCH];
  int n_busy = 0, n_done = 0, done_cyc = -1;

  task automatic clr();
    for (int k = 0; k < NCH; k++) begin cnt[k] = 0; first[k] = -1; end
    n_busy = 0; n_done = 0; done_cyc = -1;
  endtask

  // Per-cycle compare against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("ce_st", ce_st, exp_ce());
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    for (int k = 0; k < NCH; k++) begin
      if (ce_st[k]) begin
        cnt[k]++;
        if (first[k] < 0) first[k] = cyc;
      end
    end
    if (busy) n_busy++;
    if (done) begin n_done++; done_cyc = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int t;
  int tot;

  initial begin
    clr();
    step(2);
    rst = 0;

    // Reset asserted mid-RUN clears outputs within the same cycle.
    mode = 2'b00; en = 1; period = 16'd8;
    step(5);
    at_neg();
    chk("busy_pre_rst", busy, 1);
    #2 rst = 1;
    #1;
    chk("rst_ce", ce_st, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step(2);
    rst = 0; mode = 2'b11; en = 1;
    clr();
    for (int i = 0; i < 10; i++) begin
      start = 1; step(5); start = 0; step(5);
    end
    tot = 0;
    for (int k = 0; k < NCH; k++) tot += cnt[k];
    chk("rsv_busy", n_busy, 0);
    chk("rsv_strobes", tot, 0);
    chk("rsv_done", n_done, 0);

    // Continuous, period 8: offsets 0,2,4,6.
    en = 0; mode = 2'b00; period = 16'd8;
    step(2);
    en = 1;
    step(1); at_neg(); chk("cont_cb0", ce_st, 4'b0001);
    step(1); at_neg(); chk("cont_cb1", ce_st, 4'b0000);
    step(1); at_neg(); chk("cont_cb2", ce_st, 4'b0010);
    step(2); at_neg(); chk("cont_cb4", ce_st, 4'b0100);
    step(2); at_neg(); chk("cont_cb6", ce_st, 4'b1000);
    step(2); at_neg(); chk("cont_wrap", ce_st, 4'b0001);
    step(1); clr(); step(32);
    for (int k = 0; k < NCH; k++) chk("cont_cnt", cnt[k], 4);
    step(7);
    en = 0;
    at_neg(); chk("cont_masked", ce_st, 4'b0000); chk("cont_busy_masked", busy, 1);
    step(1); at_neg(); chk("cont_idle", busy, 0);
    step(1); step(1);
    en = 1;
    step(1); at_neg(); chk("cont_reen", ce_st, 4'b0001);
    en = 0;
    step(3);

    // Burst of 3 periods, start held high for 50 cycles.
    mode = 2'b01; burst_len = 8'd3; period = 16'd8; start = 0;
    step(2);
    clr(); start = 1; t = cyc;
    step(10); en = 1; step(10); en = 0; step(30);
    start = 0;
    for (int k = 0; k < NCH; k++) chk("burst_cnt", cnt[k], 3);
    chk("burst_first0", first[0], t + 1);
    chk("burst_first1", first[1], t + 3);
    chk("burst_first3", first[3], t + 7);
    chk("burst_busy", n_busy, 24);
    chk("burst_ndone", n_done, 1);
    chk("burst_donecyc", done_cyc, t + 25);

    // Single shot, period 12: offsets 0,3,6,9.
    mode = 2'b10; period = 16'd12;
    step(2);
    clr(); start = 1; t = cyc;
    step(1); start = 0; step(20);
    for (int k = 0; k < NCH; k++) begin
      chk("single_cnt", cnt[k], 1);
      chk("single_first", first[k], t + 1 + 3 * k);
    end
    chk("single_busy", n_busy, 12);
    chk("single_ndone", n_done, 1);
    chk("single_donecyc", done_cyc, t + 13);

    // Zero-length burst is ignored.
    mode = 2'b01; burst_len = 8'd0;
    step(1);
    clr(); start = 1; step(3); start = 0; step(10);
    chk("zero_busy", n_busy, 0);
    chk("zero_done", n_done, 0);

    // Clamp: period 1 becomes 4, strobes on consecutive cycles.
    mode = 2'b00; period = 16'd1; en = 1;
    step(1); at_neg(); chk("clamp0", ce_st, 4'b0001);
    step(1); at_neg(); chk("clamp1", ce_st, 4'b0010);
    step(1); at_neg(); chk("clamp2", ce_st, 4'b0100);
    step(1); at_neg(); chk("clamp3", ce_st, 4'b1000);
    step(1); at_neg(); chk("clamp_wrap", ce_st, 4'b0001);
    period = 16'd8;
    step(1); at_neg(); chk("clamp_hold", ce_st, 4'b0010);
    en = 0;
    step(2);
    en = 1;
    step(1); at_neg(); chk("relatch0", ce_st, 4'b0001);
    step(1); at_neg(); chk("relatch1", ce_st, 4'b0000);
    step(1); at_neg(); chk("relatch2", ce_st, 4'b0010);
    en = 0;
    step(2);

    // Retrigger in the done cycle.
    mode = 2'b01; burst_len = 8'd2; period = 16'd4; start = 0;
    step(1);
    clr(); start = 1; t = cyc;
    step(1); start = 0; step(7);
    step(1);
    start = 1;
    at_neg(); chk("retrig_done", done, 1); chk("retrig_idle", busy, 0);
    step(1); at_neg(); chk("retrig_busy", busy, 1); chk("retrig_ce", ce_st, 4'b0001);
    start = 0;
    step(12);
    chk("retrig_ndone", n_done, 2);
    chk("retrig_nbusy", n_busy, 16);
    chk("retrig_donecyc", done_cyc, t + 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
